// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if: handshake between main control FSM and the mult/div sequencer
interface muldiv_sequencer_if;
  logic start;
  logic op;
  logic abort;
  logic div_zero;
  logic busy;
  logic unit_rst;
  logic divOrMult;
  logic HILO_W;
  logic done;
  logic exc_div0;
  modport master (
    output start, op, abort, div_zero,
    input  busy, unit_rst, divOrMult, HILO_W, done, exc_div0
  );
  modport slave (
    input  start, op, abort, div_zero,
    output busy, unit_rst, divOrMult, HILO_W, done, exc_div0
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: clears, times and commits the shared mult/div unit into HI/LO.
// Define MULDIV_DIV0_EXC_EN to raise exc_div0 on a divide by zero instead of writing HI/LO.
module muldiv_sequencer #(
  parameter int MULT_CYCLES = 32,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 6
) (
  input logic clk,
  input logic reset,
  muldiv_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, CLEAR, RUN, WRITE, EXC} state_t;
  state_t state, nxt;
  logic op_q;
  logic [CNT_W-1:0] cnt;
  logic div0;
`ifdef MULDIV_DIV0_EXC_EN
  assign div0 = op_q & bus.div_zero;
`else
  logic unused_div_zero;
  assign unused_div_zero = bus.div_zero;
  assign div0 = 1'b0;
`endif
  assign bus.divOrMult = op_q;
  always_comb begin
    nxt = state == IDLE  ? ((bus.start && !bus.abort) ? CLEAR : IDLE)
        : state == CLEAR ? (bus.abort ? IDLE : RUN)
        : state == RUN   ? (bus.abort ? IDLE : div0 ? EXC : (cnt == '0) ? WRITE : RUN)
        : IDLE;
  end
  // outputs are registered from the next state so they line up with the state they describe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      op_q         <= 1'b0;
      cnt          <= '0;
      bus.busy     <= 1'b0;
      bus.unit_rst <= 1'b0;
      bus.HILO_W   <= 1'b0;
      bus.done     <= 1'b0;
      bus.exc_div0 <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && nxt == CLEAR) op_q <= bus.op;
      if (state == CLEAR) cnt <= CNT_W'(op_q ? DIV_CYCLES - 1 : MULT_CYCLES - 1);
      else if (state == RUN && cnt != '0) cnt <= cnt - 1'b1;
      bus.busy     <= nxt != IDLE;
      bus.unit_rst <= nxt == CLEAR;
      bus.HILO_W   <= nxt == WRITE;
      bus.done     <= nxt == WRITE || nxt == EXC;
      bus.exc_div0 <= nxt == EXC;
    end
  end
endmodule
